data_sram_like_bridge: RTL and testbench

DATA_SRAM_LIKE_BRIDGE -- requirements
Module: data_sram_like_bridge

---
 rtl/data_sram_like_bridge_pkg.sv | 29 ++
 rtl/data_sram_like_bridge.sv | 107 ++++++++++
 tb/tb_data_sram_like_bridge.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/data_sram_like_bridge_pkg.sv
// Shared definitions for the data SRAM to SRAM-like bridge: FSM states,
// access-size codes and the byte-enable to size/strobe mapping.
package data_sram_like_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // A read (wen 0000) is a full word fetch with no strobes.
  function automatic logic [1:0] wen_to_size(input logic [3:0] wen);
    case (wen)
      4'b0011, 4'b1100:                   return SIZE_HALF;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return SIZE_BYTE;
      default:                            return SIZE_WORD;
    endcase
  endfunction

  function automatic logic [3:0] wen_to_wstrb(input logic [3:0] wen);
    return wen;
  endfunction

endpackage

// File: rtl/data_sram_like_bridge.sv
// Bridges the core's single-cycle data SRAM port onto an addr_ok/data_ok
// SRAM-like bus, stalling the pipeline. DATA_BRIDGE_WR_BUF_EN adds a posted write buffer.
module data_sram_like_bridge
  import data_sram_like_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq_for_mem,
  output logic        req,
  output logic        wr,
  output logic [1:0]  size,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] rdata
);

`ifdef DATA_BRIDGE_WR_BUF_EN
  localparam bit WR_BUF = 1'b1;
`else
  localparam bit WR_BUF = 1'b0;
`endif

  // Handshake: the slave takes the request on a cycle with req && addr_ok;
  // the transaction ends on the first data_ok after that (or the same cycle).
  state_t      state, state_next;
  logic [3:0]  wen_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        buf_valid;
  logic        accept, post, finish, capture, stall;

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    accept     = 1'b0;
    post       = 1'b0;
    finish     = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (data_sram_en && !rst) begin
          accept     = 1'b1;
          post       = WR_BUF && (data_sram_wen != 4'b0000);
          stall      = !post;
          state_next = ADDR;
        end
      end
      ADDR: begin
        // A draining posted write only holds back a newly arriving request.
        stall = buf_valid ? data_sram_en : 1'b1;
        if (addr_ok) begin
          finish     = data_ok;
          state_next = data_ok ? DONE : DATA;
        end
      end
      DATA: begin
        stall = buf_valid ? data_sram_en : 1'b1;
        if (data_ok) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (finish && buf_valid) state_next = IDLE;
    capture = finish && (wen_q == 4'b0000);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wen_q     <= 4'b0000;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      rdata_q   <= 32'h0;
      buf_valid <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        wen_q   <= data_sram_wen;
        addr_q  <= data_sram_addr;
        wdata_q <= data_sram_wdata;
      end
      if (capture) rdata_q <= rdata;
      if (post) buf_valid <= 1'b1;
      else if (finish) buf_valid <= 1'b0;
    end
  end

  assign stallreq_for_mem = stall;
  assign req              = (state == ADDR);
  assign wr               = |wen_q;
  assign size             = wen_to_size(wen_q);
  assign addr             = addr_q;
  assign wdata            = wdata_q;
  assign wstrb            = wen_to_wstrb(wen_q);
  assign data_sram_rdata  = rdata_q;

endmodule

// File: tb/tb_data_sram_like_bridge.sv
// Directed bench for data_sram_like_bridge: per-cycle expectations derived from
// transaction timing (wait counts) and checked at the falling edge.
module tb_data_sram_like_bridge;

  localparam int W = 106;

`ifdef DATA_BRIDGE_WR_BUF_EN
  localparam bit WB_MODE = 1'b1;
`else
  localparam bit WB_MODE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_sram_en = 1'b0;
  logic [3:0]  data_sram_wen = 4'b0000;
  logic [31:0] data_sram_addr = 32'h0;
  logic [31:0] data_sram_wdata = 32'h0;
  logic [31:0] data_sram_rdata;
  logic        stallreq_for_mem;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        addr_ok = 1'b0;
  logic        data_ok = 1'b0;
  logic [31:0] rdata = 32'h0;

  data_sram_like_bridge dut (
    .clk(clk), .rst(rst),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata), .stallreq_for_mem(stallreq_for_mem),
    .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  always #5 clk = ~clk;

  // Expected word: {chk, stall, req, wr, size, addr, wdata, wstrb, rdata}
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_pass = 0;
  int           n_hs = 0;
  int           n_hs_exp = 0;
  logic [31:0]  model_rdata = 32'h0;

  function automatic logic [1:0] model_size(input logic [3:0] w);
    int n;
    n = $countones(w);
    if (n == 2) return 2'd1;
    if (n == 1) return 2'd0;
    return 2'd2;
  endfunction

  function automatic void push(input bit chk, input bit stall, input bit rq,
                               input logic [3:0] w, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] rv);
    exp_q.push_back({chk, stall, rq, (w != 4'b0000), model_size(w), a, wd, w, rv});
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, expv);
  endtask

  task automatic compare_loop();
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (req && addr_ok) n_hs++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e[105]) begin
          check("stall", 32'(stallreq_for_mem), 32'(e[104]));
          check("req", 32'(req), 32'(e[103]));
          check("data_sram_rdata", data_sram_rdata, e[31:0]);
          if (e[103]) begin
            check("wr", 32'(wr), 32'(e[102]));
            check("size", 32'(size), 32'(e[101:100]));
            check("addr", addr, e[99:68]);
            check("wdata", wdata, e[67:36]);
            check("wstrb", 32'(wstrb), 32'(e[35:32]));
          end
        end
      end
    end
  endtask

  task automatic drive(input bit en, input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] wd, input bit aok, input bit dok,
                       input logic [31:0] rd);
    @(posedge clk);
    #1;
    data_sram_en    = en;
    data_sram_wen   = w;
    data_sram_addr  = a;
    data_sram_wdata = wd;
    addr_ok         = aok;
    data_ok         = dok;
    rdata           = rd;
  endtask

  // aw: cycles addr_ok is withheld in ADDR; dw: cycles data_ok is withheld
  // after acceptance, or negative for data_ok together with addr_ok.
  task automatic run_txn(input logic [3:0] w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input int aw, input int dw);
    bit posted, hold;
    posted = WB_MODE && (w != 4'b0000);
    hold   = !posted;
    n_hs_exp++;
    drive(1'b1, w, a, wd, 1'b0, 1'b0, rd);
    push(1'b1, !posted, 1'b0, w, a, wd, model_rdata);
    for (int k = 0; k <= aw; k++) begin
      drive(hold, hold ? w : 4'b0, hold ? a : 32'h0, hold ? wd : 32'h0,
            (k == aw), (k == aw) && (dw < 0), rd);
      push(1'b1, !posted, 1'b1, w, a, wd, model_rdata);
    end
    for (int k = 0; k <= dw; k++) begin
      drive(hold, hold ? w : 4'b0, hold ? a : 32'h0, hold ? wd : 32'h0, 1'b0, (k == dw), rd);
      push(1'b1, !posted, 1'b0, w, a, wd, model_rdata);
    end
    if (w == 4'b0000) model_rdata = rd;
    if (!posted) begin
      // DONE: the core still shows the same request; it must not be re-taken.
      drive(1'b1, w, a, wd, 1'b0, 1'b0, rd);
      push(1'b1, 1'b0, 1'b0, w, a, wd, model_rdata);
    end
    drive(1'b0, 4'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    push(1'b1, 1'b0, 1'b0, 4'b0, 32'h0, 32'h0, model_rdata);
  endtask

  initial begin
    fork
      compare_loop();
    join_none

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'b0, 32'h1234, 32'h0, 1'b0, 1'b0, 32'h0);
      push(1'b0, 1'b0, 1'b0, 4'b0, 32'h0, 32'h0, 32'h0);
    end
    drive(1'b0, 4'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    push(1'b1, 1'b0, 1'b0, 4'b0, 32'h0, 32'h0, 32'h0);

    run_txn(4'b0000, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0, 0);
    check("lit_read_data", data_sram_rdata, 32'hDEAD_BEEF);
    run_txn(4'b0100, 32'h0000_2002, 32'h00AB_0000, 32'hBADB_AD00, 0, 0);
    check("lit_store_keeps_rdata", data_sram_rdata, 32'hDEAD_BEEF);
    run_txn(4'b0000, 32'h0000_1004, 32'h0, 32'h0BAD_F00D, 5, 2);
    run_txn(4'b0000, 32'h0000_1008, 32'h0, 32'h1357_2468, 0, -1);
    check("lit_min_latency_read", data_sram_rdata, 32'h1357_2468);
    run_txn(4'b1100, 32'h0000_2006, 32'hBEEF_0000, 32'hFFFF_FFFF, 1, -1);
    run_txn(4'b1111, 32'h0000_2008, 32'hA5A5_5A5A, 32'h0, 2, 1);
    run_txn(4'b0011, 32'h0000_200C, 32'h0000_7777, 32'h0, 0, 0);
    run_txn(4'b0001, 32'h0000_2010, 32'h0000_0011, 32'h0, 0, -1);
    run_txn(4'b1000, 32'h0000_2013, 32'h2200_0000, 32'h0, 1, 0);
    run_txn(4'b0000, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, 1, 0);

    // Reset while waiting in DATA, then a stale data_ok.
    n_hs_exp++;
    drive(1'b1, 4'b0, 32'h0000_3000, 32'h0, 1'b0, 1'b0, 32'h0);
    push(1'b1, 1'b1, 1'b0, 4'b0, 32'h0000_3000, 32'h0, model_rdata);
    drive(1'b1, 4'b0, 32'h0000_3000, 32'h0, 1'b1, 1'b0, 32'h0);
    push(1'b1, 1'b1, 1'b1, 4'b0, 32'h0000_3000, 32'h0, model_rdata);
    drive(1'b1, 4'b0, 32'h0000_3000, 32'h0, 1'b0, 1'b0, 32'h0);
    push(1'b1, 1'b1, 1'b0, 4'b0, 32'h0000_3000, 32'h0, model_rdata);
    rst = 1'b1;
    drive(1'b0, 4'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    push(1'b0, 1'b0, 1'b0, 4'b0, 32'h0, 32'h0, 32'h0);
    model_rdata = 32'h0;
    drive(1'b0, 4'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1234_5678);
    rst = 1'b0;
    push(1'b1, 1'b0, 1'b0, 4'b0, 32'h0, 32'h0, model_rdata);
    drive(1'b0, 4'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    push(1'b1, 1'b0, 1'b0, 4'b0, 32'h0, 32'h0, model_rdata);
    check("lit_rdata_after_reset", data_sram_rdata, 32'h0);
    check("lit_stall_after_reset", 32'(stallreq_for_mem), 32'h0);

    // A normal read after reset still works.
    run_txn(4'b0000, 32'h0000_1010, 32'h0, 32'h600D_CAFE, 0, 1);

    if (WB_MODE) begin
      // Two back-to-back word stores through the posted buffer.
      n_hs_exp += 2;
      drive(1'b1, 4'hF, 32'h0000_5000, 32'h1111_1111, 1'b0, 1'b0, 32'h0);
      push(1'b1, 1'b0, 1'b0, 4'hF, 32'h0000_5000, 32'h1111_1111, model_rdata);
      drive(1'b1, 4'hF, 32'h0000_5004, 32'h2222_2222, 1'b1, 1'b0, 32'h0);
      push(1'b1, 1'b1, 1'b1, 4'hF, 32'h0000_5000, 32'h1111_1111, model_rdata);
      drive(1'b1, 4'hF, 32'h0000_5004, 32'h2222_2222, 1'b0, 1'b0, 32'h0);
      push(1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0, model_rdata);
      drive(1'b1, 4'hF, 32'h0000_5004, 32'h2222_2222, 1'b0, 1'b1, 32'h0);
      push(1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0, model_rdata);
      drive(1'b1, 4'hF, 32'h0000_5004, 32'h2222_2222, 1'b0, 1'b0, 32'h0);
      push(1'b1, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0, model_rdata);
      drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0);
      push(1'b1, 1'b0, 1'b1, 4'hF, 32'h0000_5004, 32'h2222_2222, model_rdata);
      drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      push(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, model_rdata);
    end

    repeat (3) @(negedge clk);
    check("handshake_count", 32'(n_hs), 32'(n_hs_exp));
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
